// File: rtl/alu_handshake.sv
// Registered 4-function ALU (ADD/SUB/AND/POPCNT) with ready/valid handshakes
// on both sides; a single result register gives 1-cycle latency at full rate.
module alu_handshake #(
    parameter  int unsigned DATA_WIDTH = 8,
    localparam int unsigned OUT_WIDTH  = DATA_WIDTH + 3
) (
    input  logic                  i_CLK,
    input  logic                  i_RST,
    input  logic [DATA_WIDTH-1:0] i_arg0,
    input  logic [DATA_WIDTH-1:0] i_arg1,
    input  logic [1:0]            i_oper,
    input  logic                  i_VALID,
    output logic                  o_READY,
    output logic                  o_VALID,
    input  logic                  i_READY,
    output logic [OUT_WIDTH-1:0]  o_Y
);

    localparam int unsigned CAT_WIDTH = 2 * DATA_WIDTH;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_AND = 2'b10;

    logic                 r_valid;
    logic [OUT_WIDTH-1:0] r_y;
    logic                 w_accept;
    logic [OUT_WIDTH-1:0] w_a;
    logic [OUT_WIDTH-1:0] w_b;
    logic [CAT_WIDTH-1:0] w_cat;
    logic [OUT_WIDTH-1:0] w_popcnt;
    logic [OUT_WIDTH-1:0] w_result;

    // Ready whenever the result slot is empty or being drained this cycle
    assign o_READY  = !i_RST && (!r_valid || i_READY);
    assign w_accept = i_VALID && o_READY;
    assign o_VALID  = r_valid;
    assign o_Y      = r_y;

    assign w_a   = OUT_WIDTH'(i_arg0);
    assign w_b   = OUT_WIDTH'(i_arg1);
    assign w_cat = {i_arg0, i_arg1};

    always_comb begin
        w_popcnt = '0;
        for (int unsigned i = 0; i < CAT_WIDTH; i++) begin
            w_popcnt = w_popcnt + OUT_WIDTH'(w_cat[i]);
        end
    end

    // Modular subtraction in OUT_WIDTH yields the sign-extended negative result
    always_comb begin
        w_result = '0;
        case (i_oper)
            OP_ADD:  w_result = w_a + w_b;
            OP_SUB:  w_result = w_a - w_b;
            OP_AND:  w_result = w_a & w_b;
            default: w_result = w_popcnt;
        endcase
    end

    always_ff @(posedge i_CLK) begin
        if (i_RST) begin
            r_valid <= 1'b0;
            r_y     <= '0;
        end else if (w_accept) begin
            r_valid <= 1'b1;
            r_y     <= w_result;
        end else if (i_READY) begin
            r_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_handshake.sv
// Self-checking bench for alu_handshake: directed vector table, backpressure,
// streaming against a reference model, and reset in the middle of a stream.
module tb_alu_handshake;

    localparam int unsigned DW = 8;
    localparam int unsigned OW = DW + 3;

    logic          i_CLK;
    logic          i_RST;
    logic [DW-1:0] i_arg0;
    logic [DW-1:0] i_arg1;
    logic [1:0]    i_oper;
    logic          i_VALID;
    logic          o_READY;
    logic          o_VALID;
    logic          i_READY;
    logic [OW-1:0] o_Y;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [DW-1:0] a;
        logic [DW-1:0] b;
        logic [1:0]    op;
        logic [OW-1:0] exp;
    } vec_t;

    vec_t vecs[12];

    alu_handshake #(.DATA_WIDTH(DW)) dut (
        .i_CLK   (i_CLK),
        .i_RST   (i_RST),
        .i_arg0  (i_arg0),
        .i_arg1  (i_arg1),
        .i_oper  (i_oper),
        .i_VALID (i_VALID),
        .o_READY (o_READY),
        .o_VALID (o_VALID),
        .i_READY (i_READY),
        .o_Y     (o_Y)
    );

    initial i_CLK = 1'b0;
    always #5 i_CLK = ~i_CLK;

    task automatic tick();
        @(posedge i_CLK);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [OW-1:0] model(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                            input logic [1:0] op);
        case (op)
            2'b00:   return OW'(a) + OW'(b);
            2'b01:   return OW'(a) - OW'(b);
            2'b10:   return OW'(a & b);
            default: return OW'($countones({a, b}));
        endcase
    endfunction

    task automatic drive(input logic [DW-1:0] a, input logic [DW-1:0] b, input logic [1:0] op,
                         input logic v, input logic r);
        i_arg0  = a;
        i_arg1  = b;
        i_oper  = op;
        i_VALID = v;
        i_READY = r;
    endtask

    initial begin
        logic [DW-1:0] sa;
        logic [DW-1:0] sb;
        logic [1:0]    sop;
        logic [OW-1:0] sexp;

        vecs[0]  = '{8'hFF, 8'hFF, 2'b00, 11'h1FE};
        vecs[1]  = '{8'h03, 8'h05, 2'b01, 11'h7FE};
        vecs[2]  = '{8'h05, 8'h03, 2'b01, 11'h002};
        vecs[3]  = '{8'h00, 8'hFF, 2'b01, 11'h701};
        vecs[4]  = '{8'hF0, 8'h3C, 2'b10, 11'h030};
        vecs[5]  = '{8'hFF, 8'h01, 2'b11, 11'd9};
        vecs[6]  = '{8'h00, 8'h00, 2'b11, 11'd0};
        vecs[7]  = '{8'h00, 8'h00, 2'b00, 11'h000};
        vecs[8]  = '{8'hFF, 8'hFF, 2'b11, 11'd16};
        vecs[9]  = '{8'hFF, 8'h00, 2'b01, 11'h0FF};
        vecs[10] = '{8'hFF, 8'hFF, 2'b10, 11'h0FF};
        vecs[11] = '{8'h12, 8'h34, 2'b00, 11'h046};

        // Reset state
        i_RST = 1'b1;
        drive(8'h00, 8'h00, 2'b00, 1'b0, 1'b0);
        tick();
        tick();
        check("rst_valid", 32'(o_VALID), 32'd0);
        check("rst_y", 32'(o_Y), 32'd0);
        check("rst_ready", 32'(o_READY), 32'd0);
        i_RST = 1'b0;
        #1;
        check("post_rst_ready", 32'(o_READY), 32'd1);

        // Directed vector table, one accept per entry
        for (int i = 0; i < 12; i++) begin
            drive(vecs[i].a, vecs[i].b, vecs[i].op, 1'b1, 1'b1);
            tick();
            i_VALID = 1'b0;
            check($sformatf("vec%0d_valid", i), 32'(o_VALID), 32'd1);
            check($sformatf("vec%0d_y", i), 32'(o_Y), 32'(vecs[i].exp));
        end

        // Drain with no new accept clears valid
        drive(8'h00, 8'h00, 2'b00, 1'b0, 1'b1);
        tick();
        check("drain_valid", 32'(o_VALID), 32'd0);
        check("drain_y_kept", 32'(o_Y), 32'h046);

        // Backpressure: load A, then hold B pending while downstream stalls
        drive(8'h10, 8'h20, 2'b00, 1'b1, 1'b0);
        tick();
        check("bp_load_valid", 32'(o_VALID), 32'd1);
        check("bp_load_y", 32'(o_Y), 32'h030);
        drive(8'h09, 8'h01, 2'b01, 1'b1, 1'b0);
        for (int c = 0; c < 3; c++) begin
            check($sformatf("bp%0d_ready", c), 32'(o_READY), 32'd0);
            tick();
            check($sformatf("bp%0d_valid", c), 32'(o_VALID), 32'd1);
            check($sformatf("bp%0d_y", c), 32'(o_Y), 32'h030);
        end
        i_READY = 1'b1;
        #1;
        check("bp_release_ready", 32'(o_READY), 32'd1);
        tick();
        check("bp_release_valid", 32'(o_VALID), 32'd1);
        check("bp_release_y", 32'(o_Y), 32'h008);

        // Input changes without an accept must not disturb the result
        drive(8'hAA, 8'h55, 2'b00, 1'b0, 1'b1);
        tick();
        check("noacc_valid", 32'(o_VALID), 32'd0);
        check("noacc_y", 32'(o_Y), 32'h008);
        drive(8'h77, 8'h11, 2'b11, 1'b0, 1'b1);
        tick();
        check("noacc2_y", 32'(o_Y), 32'h008);

        // Streaming: one result per cycle, in order
        for (int i = 0; i < 20; i++) begin
            sa   = DW'(i * 37 + 5);
            sb   = DW'(i * 91 + 3);
            sop  = 2'(i % 4);
            sexp = model(sa, sb, sop);
            drive(sa, sb, sop, 1'b1, 1'b1);
            #1;
            if (i > 0) check($sformatf("stream%0d_ready", i), 32'(o_READY), 32'd1);
            tick();
            check($sformatf("stream%0d_valid", i), 32'(o_VALID), 32'd1);
            check($sformatf("stream%0d_y", i), 32'(o_Y), 32'(sexp));
        end

        // Reset while a result is valid and another is being offered
        drive(8'h01, 8'h02, 2'b00, 1'b1, 1'b0);
        i_RST = 1'b1;
        #1;
        check("midrst_ready_during", 32'(o_READY), 32'd0);
        tick();
        check("midrst_valid", 32'(o_VALID), 32'd0);
        check("midrst_y", 32'(o_Y), 32'd0);
        check("midrst_ready", 32'(o_READY), 32'd0);
        i_RST   = 1'b0;
        i_VALID = 1'b0;
        #1;
        check("midrst_ready_after", 32'(o_READY), 32'd1);
        tick();
        check("midrst_idle_valid", 32'(o_VALID), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
